// File: rtl/sdram_arbit_pkg.sv
// Shared definitions for the SDRAM command arbiter: command encodings, the
// {cs,ras,cas,we} bit order, and the one-hot arbiter state encoding.
package sdram_arbit_pkg;

    // Command bus bit positions within {cs,ras,cas,we}
    localparam int unsigned CMD_CS_BIT  = 3;
    localparam int unsigned CMD_RAS_BIT = 2;
    localparam int unsigned CMD_CAS_BIT = 1;
    localparam int unsigned CMD_WE_BIT  = 0;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_PRECH = 4'b0010;

    // One-hot arbiter states
    typedef enum logic [4:0] {
        StInit  = 5'b00001,
        StArbit = 5'b00010,
        StAref  = 5'b00100,
        StWrite = 5'b01000,
        StRead  = 5'b10000
    } arb_state_e;

endpackage

// File: rtl/sdram_arbit_ref_timer.sv
// Periodic refresh timer. Counts while run is high, raises ref_req every
// REF_PERIOD_CYC cycles and flags ref_overrun (sticky) when a period expires
// with the previous request still unserved. ack clears ref_req.
module sdram_arbit_ref_timer #(
    parameter int unsigned REF_PERIOD_CYC = 780
) (
    input  logic sclk,
    input  logic reset,
    input  logic run,
    input  logic ack,
    output logic ref_req,
    output logic ref_overrun
);

    localparam int unsigned CNT_W = (REF_PERIOD_CYC > 1) ? $clog2(REF_PERIOD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REF_PERIOD_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             expire;

    assign expire = run && (cnt_q == CNT_MAX);

    // Counter held at zero while not running; request and overrun flags
    always_ff @(posedge sclk) begin
        if (reset) begin
            cnt_q       <= '0;
            ref_req     <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (!run || expire) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            // A fresh expiry wins over a same-cycle acknowledge
            ref_req <= expire | (ref_req & ~ack);
            if (expire && ref_req) begin
                ref_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter. Grants the command bus to the init, auto-refresh,
// write or read engine and muxes the granted engine onto the pins.
// Refresh always has top priority; write beats read unless SDRAM_ARB_RR_EN is
// defined, in which case write and read alternate when both are pending.
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int unsigned REF_PERIOD_CYC = 780,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned BA_W           = 2
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              init_done,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_bank,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              aref_end,
    input  logic              wr_end,
    input  logic              rd_end,
    input  logic              wr_trig,
    input  logic              rd_trig,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              ref_req,
    output logic              ref_overrun,
    output logic [3:0]        sdram_cmd,
    output logic [BA_W-1:0]   sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr
);

    arb_state_e state_q;
    logic       wr_pend_q;
    logic       rd_pend_q;
    logic       pick_aref;
    logic       pick_wr;
    logic       pick_rd;
    logic       timer_run;
`ifdef SDRAM_ARB_RR_EN
    logic       prefer_wr_q;
`endif

    assign timer_run = (state_q != StInit);

    sdram_arbit_ref_timer #(
        .REF_PERIOD_CYC (REF_PERIOD_CYC)
    ) u_ref_timer (
        .sclk        (sclk),
        .reset       (reset),
        .run         (timer_run),
        .ack         (pick_aref),
        .ref_req     (ref_req),
        .ref_overrun (ref_overrun)
    );

    // Arbitration decision, only meaningful in ARBIT; uses registered ref_req
    always_comb begin
        pick_aref = 1'b0;
        pick_wr   = 1'b0;
        pick_rd   = 1'b0;
        if (state_q == StArbit) begin
            if (ref_req) begin
                pick_aref = 1'b1;
            end else if (wr_pend_q && rd_pend_q) begin
`ifdef SDRAM_ARB_RR_EN
                pick_wr = prefer_wr_q;
                pick_rd = ~prefer_wr_q;
`else
                pick_wr = 1'b1;
`endif
            end else if (wr_pend_q) begin
                pick_wr = 1'b1;
            end else if (rd_pend_q) begin
                pick_rd = 1'b1;
            end
        end
    end

    // Arbiter FSM with registered grants and request latches
    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q   <= StInit;
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            prefer_wr_q <= 1'b1;
`endif
        end else begin
            // A trig coinciding with the clear keeps the request pending
            wr_pend_q <= wr_trig | (wr_pend_q & ~pick_wr);
            rd_pend_q <= rd_trig | (rd_pend_q & ~pick_rd);
`ifdef SDRAM_ARB_RR_EN
            if (pick_wr) begin
                prefer_wr_q <= 1'b0;
            end else if (pick_rd) begin
                prefer_wr_q <= 1'b1;
            end
`endif
            unique case (state_q)
                StInit: begin
                    if (init_done) state_q <= StArbit;
                end
                StArbit: begin
                    if (pick_aref) begin
                        state_q <= StAref;
                        aref_en <= 1'b1;
                    end else if (pick_wr) begin
                        state_q <= StWrite;
                        wr_en   <= 1'b1;
                    end else if (pick_rd) begin
                        state_q <= StRead;
                        rd_en   <= 1'b1;
                    end
                end
                StAref: begin
                    if (aref_end) begin
                        state_q <= StArbit;
                        aref_en <= 1'b0;
                    end
                end
                StWrite: begin
                    if (wr_end) begin
                        state_q <= StArbit;
                        wr_en   <= 1'b0;
                    end
                end
                StRead: begin
                    if (rd_end) begin
                        state_q <= StArbit;
                        rd_en   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StInit;
                    aref_en <= 1'b0;
                    wr_en   <= 1'b0;
                    rd_en   <= 1'b0;
                end
            endcase
        end
    end

    // Pin mux from the registered state; ARBIT parks the bus on NOP
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_bank = '0;
        sdram_addr = '0;
        case (state_q)
            StInit: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            StAref: begin
                sdram_cmd  = aref_cmd;
                sdram_bank = aref_bank;
                sdram_addr = aref_addr;
            end
            StWrite: begin
                sdram_cmd  = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            StRead: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: stimulus pushes expected grants
// (engine, cycle) into a queue; a negedge monitor pops and checks each grant.
module tb_sdram_arbit;

    localparam int unsigned PERIOD = 50;
    localparam logic [3:0]  NOP    = 4'b0111;

    localparam logic [17:0] INIT_BUS = {4'b0010, 2'd1, 12'h111};
    localparam logic [17:0] AREF_BUS = {4'b0001, 2'd0, 12'h222};
    localparam logic [17:0] WR_BUS   = {4'b0100, 2'd2, 12'h333};
    localparam logic [17:0] RD_BUS   = {4'b0101, 2'd3, 12'h444};
    localparam logic [17:0] NOP_BUS  = {4'b0111, 2'd0, 12'h000};

    logic        sclk = 1'b0;
    logic        reset = 1'b1;
    logic        init_done = 1'b0;
    logic [17:0] init_bus = INIT_BUS;
    logic [17:0] aref_bus = AREF_BUS;
    logic [17:0] wr_bus = WR_BUS;
    logic [17:0] rd_bus = RD_BUS;
    logic        aref_end = 1'b0, wr_end = 1'b0, rd_end = 1'b0;
    logic        wr_trig = 1'b0, rd_trig = 1'b0;
    logic        aref_en, wr_en, rd_en, ref_req, ref_overrun;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_bank;
    logic [11:0] sdram_addr;

    sdram_arbit #(
        .REF_PERIOD_CYC (PERIOD),
        .ADDR_W         (12),
        .BA_W           (2)
    ) dut (
        .sclk        (sclk),
        .reset       (reset),
        .init_done   (init_done),
        .init_cmd    (init_bus[17:14]),
        .init_bank   (init_bus[13:12]),
        .init_addr   (init_bus[11:0]),
        .aref_cmd    (aref_bus[17:14]),
        .aref_bank   (aref_bus[13:12]),
        .aref_addr   (aref_bus[11:0]),
        .wr_cmd      (wr_bus[17:14]),
        .wr_bank     (wr_bus[13:12]),
        .wr_addr     (wr_bus[11:0]),
        .rd_cmd      (rd_bus[17:14]),
        .rd_bank     (rd_bus[13:12]),
        .rd_addr     (rd_bus[11:0]),
        .aref_end    (aref_end),
        .wr_end      (wr_end),
        .rd_end      (rd_end),
        .wr_trig     (wr_trig),
        .rd_trig     (rd_trig),
        .aref_en     (aref_en),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .ref_req     (ref_req),
        .ref_overrun (ref_overrun),
        .sdram_cmd   (sdram_cmd),
        .sdram_bank  (sdram_bank),
        .sdram_addr  (sdram_addr)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int eng;  // 0 aref, 1 write, 2 read
        int at;
    } grant_t;
    grant_t sb[$];

    function automatic logic [17:0] bus_of(input int e);
        case (e)
            0:       return AREF_BUS;
            1:       return WR_BUS;
            default: return RD_BUS;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    endtask

    task automatic push(input int e, input int at);
        grant_t g;
        g.eng = e;
        g.at  = at;
        sb.push_back(g);
    endtask

    // Monitor: every rising grant must match the head of the scoreboard
    logic [2:0] en_prev = 3'b000;
    always @(negedge sclk) begin
        logic [2:0] en_now;
        grant_t     g;
        en_now = {rd_en, wr_en, aref_en};
        for (int e = 0; e < 3; e++) begin
            if (en_now[e] === 1'b1 && en_prev[e] !== 1'b1) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL grant_unexpected cycle %0d: got engine %0d, want none", cyc, e);
                end else begin
                    g = sb.pop_front();
                    check("grant_engine", e, g.eng);
                    check("grant_cycle", cyc, g.at);
                    check("grant_bus", {sdram_cmd, sdram_bank, sdram_addr}, bus_of(g.eng));
                    check("grant_onehot", $countones(en_now), 1);
                end
            end
        end
        en_prev = en_now;
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    // Reset pulse; grants must drop and the bus must show init_* one edge later
    task automatic do_reset();
        check("sb_drained", sb.size(), 0);
        reset     = 1'b1;
        init_done = 1'b0;
        tick();
        check("rst_grants", {rd_en, wr_en, aref_en}, 0);
        check("rst_bus", {sdram_cmd, sdram_bank, sdram_addr}, INIT_BUS);
        check("rst_ref_req", ref_req, 0);
        check("rst_overrun", ref_overrun, 0);
        reset = 1'b0;
        tick();
        check("init_bus_hold", {sdram_cmd, sdram_bank, sdram_addr}, INIT_BUS);
    endtask

    // Leave INIT; returns the cycle in which the state is ARBIT for the first time
    task automatic do_init(output int ta);
        repeat (3) tick();
        init_done = 1'b1;
        tick();
        ta = cyc;
        check("arbit_bus_nop", {sdram_cmd, sdram_bank, sdram_addr}, NOP_BUS);
        check("arbit_no_grant", {rd_en, wr_en, aref_en}, 0);
        check("arbit_ref_req", ref_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: got timeout, want completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ta;
        int t;
        int g;

        // Reset and first init
        do_reset();
        do_init(ta);

        // Single write: grant two cycles after trig, foreign ends ignored, release on wr_end
        t = ta + 2;
        g = t + 2;
        push(1, g);
        go_to(t);
        wr_trig = 1'b1;
        tick();
        wr_trig = 1'b0;
        go_to(g + 5);
        rd_end   = 1'b1;
        aref_end = 1'b1;
        tick();
        rd_end   = 1'b0;
        aref_end = 1'b0;
        check("end_ignored_wr_en", wr_en, 1);
        check("end_ignored_bus", {sdram_cmd, sdram_bank, sdram_addr}, WR_BUS);
        go_to(g + 19);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        check("wr_release_en", wr_en, 0);
        check("wr_release_cmd", sdram_cmd, NOP);
        go_to(g + 25);
        check("wr_no_regrant", wr_en, 0);

        // Simultaneous write/read pair, second pair during the write
        do_reset();
        do_init(ta);
        t = ta + 1;
        push(1, t + 2);
`ifdef SDRAM_ARB_RR_EN
        push(2, t + 7);
        push(1, t + 12);
`else
        push(1, t + 7);
        push(2, t + 12);
`endif
        go_to(t);
        wr_trig = 1'b1;
        rd_trig = 1'b1;
        tick();
        wr_trig = 1'b0;
        rd_trig = 1'b0;
        go_to(t + 3);
        wr_trig = 1'b1;
        rd_trig = 1'b1;
        tick();
        wr_trig = 1'b0;
        rd_trig = 1'b0;
        go_to(t + 5);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        for (int k = 0; k < 2; k++) begin
            go_to(t + 10 + 5 * k);
            wr_end = 1'b1;
            rd_end = 1'b1;
            tick();
            wr_end = 1'b0;
            rd_end = 1'b0;
        end
        go_to(t + 20);
        check("pair_idle", {rd_en, wr_en, aref_en}, 0);

        // Read trig latched during INIT, then 10 merged trigs give one extra read
        do_reset();
        rd_trig = 1'b1;
        tick();
        rd_trig = 1'b0;
        do_init(ta);
        g = ta + 1;
        push(2, g);
        push(2, g + 14);
        go_to(g + 1);
        rd_trig = 1'b1;
        repeat (10) tick();
        rd_trig = 1'b0;
        go_to(g + 12);
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        go_to(g + 17);
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        go_to(g + 28);
        check("merge_idle", {rd_en, wr_en, aref_en}, 0);

        // Long write across two refresh periods, then refresh before pending read
        do_reset();
        do_init(ta);
        push(1, ta + 2);
        push(0, ta + 123);
        push(2, ta + 128);
        wr_trig = 1'b1;
        tick();
        wr_trig = 1'b0;
        go_to(ta + 10);
        rd_trig = 1'b1;
        tick();
        rd_trig = 1'b0;
        go_to(ta + 49);
        check("ref_req_before", ref_req, 0);
        go_to(ta + 50);
        check("ref_req_set", ref_req, 1);
        check("overrun_early", ref_overrun, 0);
        go_to(ta + 99);
        check("overrun_before", ref_overrun, 0);
        go_to(ta + 100);
        check("overrun_set", ref_overrun, 1);
        check("no_preempt", wr_en, 1);
        go_to(ta + 121);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        go_to(ta + 123);
        check("ref_req_ack", ref_req, 0);
        go_to(ta + 126);
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        go_to(ta + 131);
        check("overrun_sticky", ref_overrun, 1);
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;

        // Reset in the middle of a write with a read still pending
        push(1, ta + 134);
        wr_trig = 1'b1;
        tick();
        wr_trig = 1'b0;
        go_to(ta + 135);
        rd_trig = 1'b1;
        tick();
        rd_trig = 1'b0;
        go_to(ta + 137);
        do_reset();
        do_init(ta);
        go_to(ta + 20);
        check("post_reset_no_pend", {rd_en, wr_en, aref_en}, 0);
        check("sb_final", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
